rs485_multidrop_responder: RTL and testbench
============================================

Name: rs485_multidrop_responder

Overview:
- Parametrised RS485 slave responder for the POEM/PSLV link. Successor to the fixed 16-bit address-detect/transmit pair.
- Receives 9-bit multidrop frames on the bus, with a mid-bit sampling receiver and framing check.
- On a matching address frame it enables the line driver, waits a turnaround gap, then sends a NUM_BYTES response snapshotted from data_in.
- Sits between the RS485 transceiver (rx, tx, tx_en) and the payload/housekeeping logic.

Parameters:
- SLAVE_ADDR, 8'h01: address byte this node answers to.
- NUM_BYTES, 2: response bytes per reply; legal range 1..16.
- CLKS_PER_BIT, 1: clocks per bus bit; legal range 1..1024.
- TURNAROUND, 2: idle-high clocks with tx_en=1 before the first start bit; legal range 1..255.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- rx  in  1  receive line from the transceiver; idle 1
- data_in  in  8*NUM_BYTES  response payload; byte k is data_in[8k+7:8k], and byte 0 is sent first
- tx  out  1  transmit line; idle 1
- tx_en  out  1  driver enable; 1 only while replying
- busy  out  1  high from address match until reply end
- addr_hit  out  1  one-cycle pulse on a valid matching address frame
- frame_err  out  1  one-cycle pulse when a received stop bit is 0
- tx_done  out  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n. Every flop clears immediately on reset_n=0.
- Reset values: tx=1, tx_en=0, busy=0, addr_hit=0, frame_err=0, tx_done=0. FSM=RX_IDLE, all counters 0.
- Frame format, 11 bits, LSB first: start(0), d0..d7, flag, stop(1). Each bit lasts CLKS_PER_BIT clocks.
  - flag=1 marks an address frame.
  - flag=0 marks a data frame; every reply byte uses flag=0.
- Sampling: H = CLKS_PER_BIT/2 (integer division).
  - The start bit is sampled H clocks after rx is first seen 0 in RX_IDLE. With CLKS_PER_BIT=1 that is the same cycle.
  - Each later bit is sampled every CLKS_PER_BIT clocks after that.
- FSM states: RX_IDLE, RX_START, RX_BITS, TURN, TX_BITS.
- RX_IDLE: move to RX_START when rx=0.
- RX_START: at the sample point, rx=1 means a glitch: return to RX_IDLE with no pulse. rx=0 moves to RX_BITS.
- RX_BITS: shift in d0..d7, then flag, then stop.
  - At the stop sample, cycle T:
    - stop=0: frame_err=1 at T+1, then RX_IDLE.
    - stop=1, flag=1 and byte==SLAVE_ADDR: addr_hit=1 and busy=1 at T+1, then TURN.
    - Any other stop=1 frame (data frame or other address): ignored, back to RX_IDLE.
  - No overlap: a new start bit is only searched for in RX_IDLE.
- TURN:
  - At T+1: tx_en=1, tx=1, and data_in is snapshotted into the shift buffer. Later data_in changes do not affect the reply.
  - tx stays 1 for exactly TURNAROUND clocks.
  - The first start bit drives tx at T+1+TURNAROUND.
- TX_BITS:
  - Sends bytes 0..NUM_BYTES-1 back-to-back with no inter-byte idle. Each byte is 0, d0..d7, 0, 1.
  - Total length is 11*NUM_BYTES*CLKS_PER_BIT clocks.
  - On the clock after the last stop bit: tx_en=0, busy=0 and tx_done=1 for one cycle, then RX_IDLE.
- rx is ignored from T+1 until tx_done. The local echo cannot retrigger the receiver.
- Counters:
  - bit counter 0..10
  - byte counter 0..NUM_BYTES-1, wraps to the end condition, not to 0
  - clock counter 0..CLKS_PER_BIT-1
  - turnaround counter 0..TURNAROUND-1
- Reset mid-reply: tx returns to 1 and tx_en to 0 asynchronously. No tx_done pulse; the reply is abandoned.
- Address 8'h00 (broadcast) is never answered unless SLAVE_ADDR=8'h00.

Test Plan:
- Defaults; rx sends 0,1,0,0,0,0,0,0,0,1,1 (addr 0x01, flag 1), data_in=16'hA55A -> addr_hit at T+1; tx_en at T+1; tx=1 for 2 clocks; then tx = 0,0,1,0,1,1,0,1,0,0,1,0,1,0,1,0,0,1,0,1,0,1; tx_done after 22 bits.
- Defaults; address frame 0x02 with flag 1, then 0x01 with flag 0 -> no addr_hit, tx_en stays 0, tx stays 1.
- Defaults; frame with stop bit 0 -> frame_err for one cycle, no reply; the next valid 0x01 address frame is answered normally.
- CLKS_PER_BIT=8, NUM_BYTES=3, TURNAROUND=5; 3-clock low glitch on rx -> no activity. A valid 0x01 frame then gives tx_en high for 5+264 clocks; bytes appear in order 0,1,2.
- Defaults; data_in changes from 16'h1234 to 16'hFFFF at T+3 -> transmitted bytes are 0x34, 0x12.
- Defaults; reset_n pulsed low during the 5th transmitted bit -> tx=1 and tx_en=0 immediately, no tx_done, busy=0; the next address frame is answered.

Source files
------------

// File: rtl/rs485_multidrop_responder.sv
// -----------------------------------------------------------------------------
// rs485_multidrop_responder
//
// RS485 multidrop slave responder. Receives 11-bit frames
// (start, d0..d7, flag, stop; LSB first). When an address frame (flag=1)
// matching SLAVE_ADDR arrives with a good stop bit, the node takes the bus:
//   1. It raises tx_en.
//   2. It holds tx idle-high for TURNAROUND clocks.
//   3. It sends NUM_BYTES data frames (flag=0) snapshotted from data_in.
// The receiver is deaf from the address match until tx_done, so the local
// echo of the reply cannot retrigger it.
//
// Parameters:
//   SLAVE_ADDR    address byte answered by this node
//   NUM_BYTES     reply length in bytes (1..16)
//   CLKS_PER_BIT  clocks per bus bit (1..1024)
//   TURNAROUND    idle-high clocks with tx_en=1 before the first start bit (1..255)
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   rx         receive line, idle 1. It is sampled directly; an asynchronous
//              source must be synchronised upstream of this block.
//   data_in    reply payload. Byte k is data_in[8k+7:8k]; byte 0 is sent first.
//   tx         transmit line, idle 1
//   tx_en      line driver enable, high only while replying
//   busy       high from the address match until the reply ends
//   addr_hit   one-cycle pulse on a matching address frame
//   frame_err  one-cycle pulse when a received stop bit is 0
//   tx_done    one-cycle pulse after the last stop bit of the reply
// -----------------------------------------------------------------------------
module rs485_multidrop_responder #(
    parameter logic [7:0] SLAVE_ADDR   = 8'h01,
    parameter int         NUM_BYTES    = 2,
    parameter int         CLKS_PER_BIT = 1,
    parameter int         TURNAROUND   = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   rx,
    input  logic [8*NUM_BYTES-1:0] data_in,
    output logic                   tx,
    output logic                   tx_en,
    output logic                   busy,
    output logic                   addr_hit,
    output logic                   frame_err,
    output logic                   tx_done
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int TW   = $clog2(TURNAROUND + 1);
    localparam int BW   = $clog2(NUM_BYTES + 1);

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CLK_HALF  = CW'(HALF);
    localparam logic [CW-1:0] CLK_ONE   = CW'(1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURNAROUND - 1);
    localparam logic [TW-1:0] TURN_ONE  = TW'(1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NUM_BYTES - 1);
    localparam logic [BW-1:0] BYTE_ONE  = BW'(1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_BITS,
        TURN,
        TX_BITS
    } state_t;

    state_t                   state_q;
    logic [CW-1:0]            clk_cnt_q;
    logic [3:0]               bit_cnt_q;
    logic [BW-1:0]            byte_cnt_q;
    logic [TW-1:0]            turn_cnt_q;
    logic [8:0]               rx_sr_q;    // {flag, d7..d0} once nine bits are in
    logic [8*NUM_BYTES-1:0]   tx_buf_q;   // reply snapshot; shifts out LSB first
    logic                     tx_q;
    logic                     tx_en_q;
    logic                     busy_q;
    logic                     addr_hit_q;
    logic                     frame_err_q;
    logic                     tx_done_q;

    // Last clock of the current bit period. Used for both receive and transmit.
    logic clk_wrap_d;
    always_comb begin
        clk_wrap_d = (clk_cnt_q == CLK_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RX_IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            turn_cnt_q  <= '0;
            rx_sr_q     <= '0;
            tx_buf_q    <= '0;
            tx_q        <= 1'b1;
            tx_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            addr_hit_q  <= 1'b0;
            frame_err_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            addr_hit_q  <= 1'b0;
            frame_err_q <= 1'b0;
            tx_done_q   <= 1'b0;

            case (state_q)
                RX_IDLE: begin
                    if (!rx) begin
                        bit_cnt_q <= '0;
                        if (HALF == 0) begin
                            // With one clock per bit, the first low sample is
                            // itself the start-bit sample point.
                            clk_cnt_q <= '0;
                            state_q   <= RX_BITS;
                        end else begin
                            // This cycle is clock 0 of the start bit, so the
                            // count resumes at 1 in RX_START.
                            clk_cnt_q <= CLK_ONE;
                            state_q   <= RX_START;
                        end
                    end
                end

                RX_START: begin
                    if (clk_cnt_q == CLK_HALF) begin
                        clk_cnt_q <= '0;
                        state_q   <= rx ? RX_IDLE : RX_BITS;  // high at mid-bit: glitch
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CLK_ONE;
                    end
                end

                RX_BITS: begin
                    if (clk_wrap_d) begin
                        clk_cnt_q <= '0;
                        if (bit_cnt_q == 4'd9) begin
                            // Stop-bit sample point.
                            bit_cnt_q <= '0;
                            if (!rx) begin
                                frame_err_q <= 1'b1;
                                state_q     <= RX_IDLE;
                            end else if (rx_sr_q[8] && (rx_sr_q[7:0] == SLAVE_ADDR)) begin
                                addr_hit_q <= 1'b1;
                                busy_q     <= 1'b1;
                                tx_en_q    <= 1'b1;
                                tx_q       <= 1'b1;
                                tx_buf_q   <= data_in;
                                turn_cnt_q <= '0;
                                state_q    <= TURN;
                            end else begin
                                state_q <= RX_IDLE;
                            end
                        end else begin
                            rx_sr_q   <= {rx, rx_sr_q[8:1]};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CLK_ONE;
                    end
                end

                TURN: begin
                    if (turn_cnt_q == TURN_LAST) begin
                        // Register the start bit so it appears once the
                        // idle-high gap has lasted exactly TURNAROUND clocks.
                        turn_cnt_q <= '0;
                        tx_q       <= 1'b0;
                        clk_cnt_q  <= '0;
                        bit_cnt_q  <= '0;
                        byte_cnt_q <= '0;
                        state_q    <= TX_BITS;
                    end else begin
                        turn_cnt_q <= turn_cnt_q + TURN_ONE;
                    end
                end

                TX_BITS: begin
                    // tx_q holds the bit indexed by bit_cnt_q. On the last
                    // clock of that bit, the next bit is loaded.
                    if (clk_wrap_d) begin
                        clk_cnt_q <= '0;
                        if (bit_cnt_q == 4'd10) begin
                            bit_cnt_q <= '0;
                            if (byte_cnt_q == BYTE_LAST) begin
                                byte_cnt_q <= '0;
                                tx_q       <= 1'b1;
                                tx_en_q    <= 1'b0;
                                busy_q     <= 1'b0;
                                tx_done_q  <= 1'b1;
                                state_q    <= RX_IDLE;
                            end else begin
                                byte_cnt_q <= byte_cnt_q + BYTE_ONE;
                                tx_q       <= 1'b0;  // next start bit, no idle gap
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q <= 4'd7) begin
                                // After eight shifts, the next byte sits at the bottom.
                                tx_q     <= tx_buf_q[0];
                                tx_buf_q <= tx_buf_q >> 1;
                            end else if (bit_cnt_q == 4'd8) begin
                                tx_q <= 1'b0;        // flag: reply bytes are data frames
                            end else begin
                                tx_q <= 1'b1;        // stop
                            end
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CLK_ONE;
                    end
                end

                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign tx        = tx_q;
    assign tx_en     = tx_en_q;
    assign busy      = busy_q;
    assign addr_hit  = addr_hit_q;
    assign frame_err = frame_err_q;
    assign tx_done   = tx_done_q;

endmodule

// File: tb/tb_rs485_multidrop_responder.sv
// -----------------------------------------------------------------------------
// tb_rs485_multidrop_responder
//
// Directed bench with two responders:
//   DUT 0 (index 0) uses the default parameters.
//   DUT 1 (index 1) uses CLKS_PER_BIT=8, NUM_BYTES=3, TURNAROUND=5.
// A negedge monitor logs tx while tx_en is high and counts output pulses.
// Expected values are hand-computed constants or derived from the frame format.
// -----------------------------------------------------------------------------
module tb_rs485_multidrop_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rx_a, rx_b;
    logic [15:0] data_a;
    logic [23:0] data_b;
    logic [1:0]  tx_s, tx_en_s, busy_s, hit_s, ferr_s, done_s;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    rs485_multidrop_responder u_dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx        (rx_a),
        .data_in   (data_a),
        .tx        (tx_s[0]),
        .tx_en     (tx_en_s[0]),
        .busy      (busy_s[0]),
        .addr_hit  (hit_s[0]),
        .frame_err (ferr_s[0]),
        .tx_done   (done_s[0])
    );

    rs485_multidrop_responder #(
        .SLAVE_ADDR   (8'h01),
        .NUM_BYTES    (3),
        .CLKS_PER_BIT (8),
        .TURNAROUND   (5)
    ) u_dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx        (rx_b),
        .data_in   (data_b),
        .tx        (tx_s[1]),
        .tx_en     (tx_en_s[1]),
        .busy      (busy_s[1]),
        .addr_hit  (hit_s[1]),
        .frame_err (ferr_s[1]),
        .tx_done   (done_s[1])
    );

    // ---------------- monitor ----------------
    logic qa[$];
    logic qb[$];
    int   hit_cnt[2]  = '{0, 0};
    int   ferr_cnt[2] = '{0, 0};
    int   done_cnt[2] = '{0, 0};
    int   en_cnt[2]   = '{0, 0};
    int   idle_bad    = 0;
    int   busy_bad    = 0;
    int   done_bad    = 0;
    logic [1:0] prev_en = 2'b00;

    always @(negedge clk) begin
        if (tx_en_s[0]) qa.push_back(tx_s[0]);
        if (tx_en_s[1]) qb.push_back(tx_s[1]);
        for (int i = 0; i < 2; i++) begin
            if (hit_s[i])                 hit_cnt[i]  <= hit_cnt[i] + 1;
            if (ferr_s[i])                ferr_cnt[i] <= ferr_cnt[i] + 1;
            if (done_s[i])                done_cnt[i] <= done_cnt[i] + 1;
            if (tx_en_s[i])               en_cnt[i]   <= en_cnt[i] + 1;
            if (!tx_en_s[i] && !tx_s[i])  idle_bad    <= idle_bad + 1;
            if (busy_s[i] != tx_en_s[i])  busy_bad    <= busy_bad + 1;
            if (done_s[i] && (!prev_en[i] || tx_en_s[i])) done_bad <= done_bad + 1;
        end
        prev_en <= tx_en_s;
    end

    // ---------------- helpers ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic flag, input logic stop);
        return {stop, flag, b, 1'b0};
    endfunction

    function automatic int qsize(input int which);
        return (which == 0) ? qa.size() : qb.size();
    endfunction

    function automatic logic qbit(input int which, input int idx);
        if (idx >= qsize(which)) return 1'bx;
        return (which == 0) ? qa[idx] : qb[idx];
    endfunction

    task automatic clear_q();
        qa.delete();
        qb.delete();
    endtask

    // Drive an 11-bit frame LSB first, c clocks per bit; rx ends idle high.
    task automatic send_frame(input int which, input logic [10:0] f);
        int c;
        c = (which == 0) ? 1 : 8;
        for (int i = 0; i < 11; i++) begin
            if (which == 0) rx_a = f[i]; else rx_b = f[i];
            repeat (c) step();
        end
        if (which == 0) rx_a = 1'b1; else rx_b = 1'b1;
    endtask

    task automatic wait_done(input int which, input int max_cyc, input string tag);
        int start;
        int n;
        start = done_cnt[which];
        n = 0;
        while (done_cnt[which] == start && n < max_cyc) begin
            step();
            n++;
        end
        check_val(tag, done_cnt[which] - start, 1);
    endtask

    // Byte b of a logged reply, sampled at each data bit's mid-point.
    function automatic logic [7:0] dec_byte(input int which, input int ta, input int c, input int b);
        logic [7:0] v;
        for (int j = 0; j < 8; j++) v[j] = qbit(which, ta + (b * 11 + 1 + j) * c + c / 2);
        return v;
    endfunction

    // Whole logged reply against the frame format: ta idle-high clocks, then
    // n frames of {0, data, 0, 1}, each bit c clocks long.
    task automatic check_reply(input string tag, input int which, input int ta, input int c,
                               input int n, input logic [127:0] data);
        int   len, bad, bi, k;
        logic e;
        len = qsize(which);
        check_val({tag, "_len"}, len, ta + 11 * n * c);
        bad = 0;
        for (int i = 0; i < len; i++) begin
            if (i < ta) begin
                e = 1'b1;
            end else begin
                bi = (i - ta) / (11 * c);
                k  = ((i - ta) / c) % 11;
                if (bi >= n)     e = 1'b1;
                else if (k == 0) e = 1'b0;
                else if (k <= 8) e = data[bi * 8 + k - 1];
                else if (k == 9) e = 1'b0;
                else             e = 1'b1;
            end
            if (qbit(which, i) !== e) bad++;
        end
        check_val({tag, "_bits"}, bad, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int h0, e0, f0, d0, bad;
        logic [0:23] exp_seq;

        rx_a    = 1'b1;
        rx_b    = 1'b1;
        data_a  = 16'hA55A;
        data_b  = 24'h3C81E7;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        check_val("rst_a", {tx_s[0], tx_en_s[0], busy_s[0], hit_s[0], ferr_s[0], done_s[0]}, 6'b100000);
        check_val("rst_b", {tx_s[1], tx_en_s[1], busy_s[1], hit_s[1], ferr_s[1], done_s[1]}, 6'b100000);
        repeat (2) step();
        reset_n = 1'b1;
        repeat (3) step();

        // 1: basic reply with default parameters
        clear_q();
        h0 = hit_cnt[0];
        send_frame(0, mk_frame(8'h01, 1'b1, 1'b1));
        check_val("t1_hit_T1", {hit_s[0], busy_s[0], tx_en_s[0], tx_s[0]}, 4'b1111);
        step();
        check_val("t1_hit_pulse", hit_s[0], 1'b0);
        wait_done(0, 100, "t1_done");
        exp_seq = 24'b110010110100101010010101;
        bad = 0;
        for (int i = 0; i < 24; i++) if (qbit(0, i) !== exp_seq[i]) bad++;
        check_val("t1_seq_len", qa.size(), 24);
        check_val("t1_seq_bad", bad, 0);
        check_val("t1_byte0", dec_byte(0, 2, 1, 0), 8'h5A);
        check_val("t1_byte1", dec_byte(0, 2, 1, 1), 8'hA5);
        check_val("t1_hits", hit_cnt[0] - h0, 1);
        repeat (3) step();

        // 2: other address, then data frame carrying our address
        h0 = hit_cnt[0];
        e0 = en_cnt[0];
        send_frame(0, mk_frame(8'h02, 1'b1, 1'b1));
        repeat (3) step();
        send_frame(0, mk_frame(8'h01, 1'b0, 1'b1));
        repeat (5) step();
        check_val("t2_no_hit", hit_cnt[0] - h0, 0);
        check_val("t2_no_en", en_cnt[0] - e0, 0);
        check_val("t2_tx_idle", tx_s[0], 1'b1);

        // 3: bad stop bit, then a good frame
        h0 = hit_cnt[0];
        f0 = ferr_cnt[0];
        e0 = en_cnt[0];
        send_frame(0, mk_frame(8'h01, 1'b1, 1'b0));
        check_val("t3_ferr_T1", ferr_s[0], 1'b1);
        step();
        check_val("t3_ferr_pulse", ferr_s[0], 1'b0);
        repeat (3) step();
        check_val("t3_ferr_cnt", ferr_cnt[0] - f0, 1);
        check_val("t3_no_hit", hit_cnt[0] - h0, 0);
        check_val("t3_no_en", en_cnt[0] - e0, 0);
        clear_q();
        send_frame(0, mk_frame(8'h01, 1'b1, 1'b1));
        wait_done(0, 100, "t3_done");
        check_reply("t3_reply", 0, 2, 1, 2, data_a);
        repeat (3) step();

        // 4: DUT 1 (8 clocks/bit, 3 bytes, turnaround 5) -- glitch, then frame
        h0 = hit_cnt[1];
        e0 = en_cnt[1];
        rx_b = 1'b0;
        repeat (3) step();
        rx_b = 1'b1;
        repeat (20) step();
        check_val("t4_glitch_hit", hit_cnt[1] - h0, 0);
        check_val("t4_glitch_en", en_cnt[1] - e0, 0);
        check_val("t4_glitch_ferr", ferr_cnt[1], 0);
        clear_q();
        send_frame(1, mk_frame(8'h01, 1'b1, 1'b1));
        wait_done(1, 2000, "t4_done");
        check_val("t4_en_cycles", en_cnt[1] - e0, 269);
        check_val("t4_byte0", dec_byte(1, 5, 8, 0), 8'hE7);
        check_val("t4_byte1", dec_byte(1, 5, 8, 1), 8'h81);
        check_val("t4_byte2", dec_byte(1, 5, 8, 2), 8'h3C);
        check_reply("t4_reply", 1, 5, 8, 3, data_b);
        repeat (3) step();

        // 5: data_in changes after the snapshot
        clear_q();
        data_a = 16'h1234;
        send_frame(0, mk_frame(8'h01, 1'b1, 1'b1));
        repeat (2) step();
        data_a = 16'hFFFF;
        wait_done(0, 100, "t5_done");
        check_val("t5_byte0", dec_byte(0, 2, 1, 0), 8'h34);
        check_val("t5_byte1", dec_byte(0, 2, 1, 1), 8'h12);
        check_reply("t5_reply", 0, 2, 1, 2, 16'h1234);
        repeat (3) step();

        // 6: reset during the 5th transmitted bit
        data_a = 16'hA55A;
        send_frame(0, mk_frame(8'h01, 1'b1, 1'b1));
        repeat (6) step();
        check_val("t6_mid_en", tx_en_s[0], 1'b1);
        d0 = done_cnt[0];
        reset_n = 1'b0;
        #1;
        check_val("t6_rst_out", {tx_s[0], tx_en_s[0], busy_s[0]}, 3'b100);
        repeat (2) step();
        reset_n = 1'b1;
        repeat (3) step();
        check_val("t6_no_done", done_cnt[0] - d0, 0);
        clear_q();
        h0 = hit_cnt[0];
        send_frame(0, mk_frame(8'h01, 1'b1, 1'b1));
        wait_done(0, 100, "t6_done");
        check_val("t6_hit", hit_cnt[0] - h0, 1);
        check_reply("t6_reply", 0, 2, 1, 2, 16'hA55A);
        repeat (3) step();

        // Monitor invariants over the whole run
        check_val("inv_idle_high", idle_bad, 0);
        check_val("inv_busy_eq_en", busy_bad, 0);
        check_val("inv_done_after_en", done_bad, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
